// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// mstatus bit positions and trap cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_READ = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_INSTR_FAULT      = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;

  localparam int IRQ_CAUSE_BASE = 16;
  localparam int IRQ_IDX_W      = 4;

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt arbiter: lowest pending channel index wins.
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         pend_i,
  output logic                 valid_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |pend_i;
    idx_o   = '0;
    // Walk downward so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) idx_o = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with Zicsr RW/RS/RC access, trap entry and MRET.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_en,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               except_i,
  input  logic [4:0]         except_cause,
  input  logic [XLEN-1:0]    except_tval,
  input  logic [XLEN-1:0]    cur_pc,
  input  logic               instr_valid,
  input  logic               retire_i,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_o,
  output logic [XLEN-1:0]    trap_vector,
  output logic [XLEN-1:0]    mepc_o
);

  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [XLEN-1:0]    mtvec_q, mtvec_d;
  logic [XLEN-1:0]    mscratch_q, mscratch_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mtval_q, mtval_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  logic [XLEN-1:0]      mstatus_rd, mie_rd, mip_rd;
  logic                 addr_hit, addr_ro;
  logic                 wr_req, wr_en;
  logic [XLEN-1:0]      new_val;
  logic                 irq_valid, irq_take, trap;
  logic [IRQ_IDX_W-1:0] irq_idx;
  logic [XLEN-1:0]      irq_cause;

  always_comb begin
    mstatus_rd                                    = '0;
    mstatus_rd[MSTATUS_MIE]                       = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE]                      = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]   = 2'b11;
    mie_rd                                        = '0;
    mie_rd[IRQ_CAUSE_BASE +: NUM_IRQ]             = mie_q;
    mip_rd                                        = '0;
    mip_rd[IRQ_CAUSE_BASE +: NUM_IRQ]             = irq_q;
  end

  always_comb begin
    csr_rdata = '0;
    addr_hit  = 1'b1;
    addr_ro   = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie_rd;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP: begin
        csr_rdata = mip_rd;
        addr_ro   = 1'b1;
      end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
      CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
      default:       addr_hit  = 1'b0;
    endcase
  end

  // Set/clear with a zero mask is a pure read and never counts as a write.
  assign wr_req = csr_en & ((csr_op == CSR_OP_RW) |
                            (((csr_op == CSR_OP_RS) | (csr_op == CSR_OP_RC)) & (|csr_wdata)));

  always_comb begin
    case (csr_op)
      CSR_OP_RW: new_val = csr_wdata;
      CSR_OP_RS: new_val = csr_rdata | csr_wdata;
      CSR_OP_RC: new_val = csr_rdata & ~csr_wdata;
      default:   new_val = csr_rdata;
    endcase
  end

  assign csr_illegal = csr_en & (~addr_hit | (addr_ro & wr_req));

  csr_irq_arbiter #(.N(NUM_IRQ)) u_irq_arb (
    .pend_i  (irq_q & mie_q),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  assign irq_take  = irq_valid & mstatus_mie_q & instr_valid;
  assign trap      = except_i | irq_take;
  assign wr_en     = wr_req & addr_hit & ~addr_ro & ~trap;
  assign irq_cause = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);

  assign trap_o      = trap;
  assign mepc_o      = mepc_q;
  // Vectored mode offsets only interrupts; exceptions always land on the base.
  assign trap_vector = {mtvec_q[XLEN-1:2], 2'b00} +
                       ((mtvec_q[0] & irq_take & ~except_i) ? (irq_cause << 2) : '0);

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    irq_d          = irq_i;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = (retire_i & ~trap) ? minstret_q + 64'd1 : minstret_q;
`endif

    if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = new_val[MSTATUS_MIE];
          mstatus_mpie_d = new_val[MSTATUS_MPIE];
        end
        CSR_MIE:       mie_d      = new_val[IRQ_CAUSE_BASE +: NUM_IRQ];
        CSR_MTVEC:     mtvec_d    = {new_val[XLEN-1:2], 1'b0, new_val[0]};
        CSR_MSCRATCH:  mscratch_d = new_val;
        CSR_MEPC:      mepc_d     = {new_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:    mcause_d   = new_val;
        CSR_MTVAL:     mtval_d    = new_val;
`ifdef CSR_COUNTERS_EN
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], new_val};
        CSR_MCYCLEH:   mcycle_d   = {new_val, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], new_val};
        CSR_MINSTRETH: minstret_d = {new_val, minstret_q[31:0]};
`endif
        default: ;
      endcase
    end

    if (mret_i && !trap) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (trap) begin
      mepc_d         = {cur_pc[XLEN-1:2], 2'b00};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      if (except_i) begin
        mcause_d = XLEN'(except_cause);
        mtval_d  = except_tval;
      end else begin
        mcause_d = {1'b1, irq_cause[XLEN-2:0]};
        mtval_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      irq_q          <= '0;
      mtvec_q        <= {RESET_MTVEC[XLEN-1:2], 1'b0, RESET_MTVEC[0]};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= '0;
      minstret_q     <= '0;
`endif
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      irq_q          <= irq_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Parametrised machine-mode CSR file; successor to the fixed 5-register CSR block.
- Sits in the data path beside the register file.
- Serves Zicsr read/modify/write ops (RW/RS/RC) and arbitrates synchronous exceptions against NUM_IRQ level interrupts.
- Sequences trap entry and MRET, and optionally carries 64-bit mcycle/minstret counters.

Parameters:
- XLEN, 32, data width of every CSR and data port (32 only for counter hi/lo split; other CSRs width-agnostic).
- NUM_IRQ, 4, external interrupt channels (1..16); channel i maps to mie/mip bit 16+i, cause 16+i.
- RESET_MTVEC, 0, reset value of mtvec.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=read only
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1/zimm operand
- csr_rdata  out  XLEN  old CSR value (combinational)
- csr_illegal  out  1  csr_en to unimplemented address, or write to read-only CSR
- except_i  in  1  synchronous exception at current instruction
- except_cause  in  5  exception code
- except_tval  in  XLEN  faulting address/instruction
- cur_pc  in  XLEN  PC of instruction in commit
- instr_valid  in  1  commit slot holds a real instruction (interrupt boundary)
- retire_i  in  1  instruction retired
- mret_i  in  1  MRET executing
- irq_i  in  NUM_IRQ  level interrupt requests (already synchronous to clk)
- trap_o  out  1  redirect fetch to trap_vector this cycle
- trap_vector  out  XLEN  trap target PC
- mepc_o  out  XLEN  current mepc (MRET target)

Behaviour:
- Addresses: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only); mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
- Reset: all CSRs 0 except mtvec=RESET_MTVEC. trap_o=0, csr_illegal=0.
- Read: csr_rdata = selected CSR (pre-write value); 0 on unimplemented address.
- Write at posedge when csr_en & op!=00 and no trap this cycle:
  - RW: new = wdata. RS: new = old | wdata. RC: new = old & ~wdata.
  - RS/RC with wdata=0 perform no write and are not illegal on read-only CSRs.
  - Write masks:
    - mstatus: only MIE(3) and MPIE(7) writable; MPP(12:11) reads 2'b11.
    - mie: only bits 16..16+NUM_IRQ-1 writable.
    - mepc[1:0] forced 0.
    - mtvec: mode bit 1 reads 0.
- mip[16+i] is irq_i registered one cycle; no other bits set.
- Interrupt pending (combinational): |(mip & mie) & mstatus.MIE & instr_valid. Lowest channel index wins.
- Trap selection, same cycle (trap_o combinational):
  - except_i has priority over interrupt.
  - On exception: mcause={0, except_cause}, mtval=except_tval.
  - On interrupt: mcause={1, 16+i}, mtval=0.
  - Both: mepc=cur_pc; MPIE<=MIE; MIE<=0.
  - trap_vector = {mtvec[XLEN-1:2],2'b00}. If mtvec[0]=1 (vectored) and interrupt, add 4*cause.
- MRET (no trap): MIE<=MPIE, MPIE<=1; mepc_o already valid.
- Simultaneous events:
  - Exception or interrupt with MRET: trap wins, MRET ignored.
  - Trap with CSR write: write suppressed.
  - Trap takes effect one cycle after the CSR write that enables it, e.g. MIE set then pending IRQ → trap next valid boundary.
- Reset mid-trap: all state returns to reset values asynchronously; no trap is recorded.

Optional Feature:
- CSR_COUNTERS_EN defined:
  - 64-bit mcycle increments every cycle; minstret increments when retire_i=1 and no trap.
  - Lo/hi readable and writable; carry from lo to hi is in the same cycle.
  - A software write to a half in a cycle replaces that cycle's increment for the whole counter.
- Undefined: counter addresses are unimplemented (read 0, csr_illegal on access); no counter flops.

Decomposition:
- Shared package csr_pkg: CSR address constants, csr_op encodings, mstatus bit indices, exception/interrupt cause codes, IRQ cause base 16.
- One sub-module csr_irq_arbiter: masked pending vector in → valid + encoded index (priority encoder, combinational).
- Counters stay inline under the macro.

Test Plan:
- Reset, then read 0x305 → RESET_MTVEC. Read 0x300 → 0x1800. Access 0x7C0 → csr_illegal=1, rdata=0.
- RW mtvec=0x100, RS mstatus 0x8, RC mstatus 0x8 → reads 0x100, 0x1808, 0x1800. Write mip → csr_illegal=1, mip unchanged.
- MIE=1, mie=0x20000, pulse irq_i=0b0010 with instr_valid, cur_pc=0x40:
  - trap_o=1 on the cycle after irq registers.
  - mcause=0x80000011, mepc=0x40, MIE=0, MPIE=1.
  - Vectored mtvec=0x101 → trap_vector=0x144.
- except_i (cause 2, tval 0xDEAD) with irq pending and mret_i in same cycle → mcause=2, mtval=0xDEAD, MRET ignored. Later mret_i → MIE=1, mepc_o=cur_pc.
- CSR RW to mscratch coincident with except_i → mscratch unchanged. Assert rst_n low mid-operation → all CSRs reset immediately.
- CSR_COUNTERS_EN: mcycle=0xFFFFFFFF, one clock → mcycle=0, mcycleh=1. 10 retire_i pulses → minstret=10.
